ex_mem: RTL and testbench

- EX→MEM pipeline register. Captures the execute-stage result: GPR write, HI/LO write, and the 2-cycle multiply-accumulate scratch state (madd/maddu/msub/msubu).
- Forwards the result to the MEM stage under the global stall vector from the pipeline controller.
- Holds the partial HI/LO product and cycle counter across the EX self-stall, and returns them to EX the next cycle.

---
 rtl/ex_mem_pkg.sv | 46 ++++
 rtl/ex_mem_if.sv | 37 +++
 rtl/ex_mem.sv | 80 ++++++++
 tb/tb_ex_mem.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared constants and types for the EX->MEM pipeline register.
// Also holds the decode of the flush/stall vector into one per-edge action.
package ex_mem_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    localparam logic RST_ENA    = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic WRITE_ENA  = 1'b1;
    localparam logic WRITE_DISA = 1'b0;

    localparam logic [REG_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    typedef logic [REG_W-1:0]   reg_bus_t;
    typedef logic [ADDR_W-1:0]  reg_addr_bus_t;
    typedef logic [2*REG_W-1:0] double_reg_bus_t;

    typedef enum logic [1:0] {
        ACT_CLEAR   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } action_t;

    // EX running with MEM stopped cannot be produced by the controller, so it falls into advance.
    function automatic action_t decode_action(input logic flush, input logic [5:0] stall);
        action_t act;
        if (flush) begin
            act = ACT_CLEAR;
        end else if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP) begin
            act = ACT_BUBBLE;
        end else if (stall[STALL_EX] == NO_STOP) begin
            act = ACT_ADVANCE;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX-to-MEM result bus plus the multiply-accumulate scratch loop back into EX.
interface ex_mem_if
    import ex_mem_pkg::*;
#(
    parameter int REG_W  = ex_mem_pkg::REG_W,
    parameter int ADDR_W = ex_mem_pkg::ADDR_W,
    parameter int CNT_W  = ex_mem_pkg::CNT_W
);
    logic                ex_wreg;
    logic [ADDR_W-1:0]   ex_waddr;
    logic [REG_W-1:0]    ex_wdata;
    logic [REG_W-1:0]    ex_hi;
    logic [REG_W-1:0]    ex_lo;
    logic                ex_whilo;
    logic [2*REG_W-1:0]  hilo_temp_i;
    logic [CNT_W-1:0]    cnt_i;

    logic                mem_wreg;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [REG_W-1:0]    mem_wdata;
    logic [REG_W-1:0]    mem_hi;
    logic [REG_W-1:0]    mem_lo;
    logic                mem_whilo;
    logic [2*REG_W-1:0]  hilo_temp_o;
    logic [CNT_W-1:0]    cnt_o;

    modport master (
        output ex_wreg, ex_waddr, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
        input  mem_wreg, mem_waddr, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o
    );

    modport slave (
        input  ex_wreg, ex_waddr, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
        output mem_wreg, mem_waddr, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// EX->MEM pipeline register: forwards the EX result under the stall vector and
// parks the madd/msub partial product and counter across the EX self-stall.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int REG_W  = ex_mem_pkg::REG_W,
    parameter int ADDR_W = ex_mem_pkg::ADDR_W,
    parameter int CNT_W  = ex_mem_pkg::CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    ex_mem_if.slave     bus
);

    localparam logic [REG_W-1:0]   ZERO_REG  = {REG_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [2*REG_W-1:0] ZERO_DBL  = {(2*REG_W){1'b0}};
    localparam logic [CNT_W-1:0]   ZERO_CNT  = {CNT_W{1'b0}};

    // Single priority-encoded register stage: reset, flush, bubble, advance, hold.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENA) begin
            bus.mem_wreg    <= WRITE_DISA;
            bus.mem_waddr   <= ZERO_ADDR;
            bus.mem_wdata   <= ZERO_REG;
            bus.mem_hi      <= ZERO_REG;
            bus.mem_lo      <= ZERO_REG;
            bus.mem_whilo   <= WRITE_DISA;
            bus.hilo_temp_o <= ZERO_DBL;
            bus.cnt_o       <= ZERO_CNT;
        end else begin
            case (decode_action(flush, stall))
                ACT_BUBBLE: begin
                    // MEM gets a no-op while EX keeps its accumulate scratch for next cycle.
                    bus.mem_wreg    <= WRITE_DISA;
                    bus.mem_waddr   <= ZERO_ADDR;
                    bus.mem_wdata   <= ZERO_REG;
                    bus.mem_hi      <= ZERO_REG;
                    bus.mem_lo      <= ZERO_REG;
                    bus.mem_whilo   <= WRITE_DISA;
                    bus.hilo_temp_o <= bus.hilo_temp_i;
                    bus.cnt_o       <= bus.cnt_i;
                end
                ACT_ADVANCE: begin
                    bus.mem_wreg    <= bus.ex_wreg;
                    bus.mem_waddr   <= bus.ex_waddr;
                    bus.mem_wdata   <= bus.ex_wdata;
                    bus.mem_hi      <= bus.ex_hi;
                    bus.mem_lo      <= bus.ex_lo;
                    bus.mem_whilo   <= bus.ex_whilo;
                    bus.hilo_temp_o <= ZERO_DBL;
                    bus.cnt_o       <= ZERO_CNT;
                end
                ACT_HOLD: begin
                    bus.mem_wreg    <= bus.mem_wreg;
                    bus.mem_waddr   <= bus.mem_waddr;
                    bus.mem_wdata   <= bus.mem_wdata;
                    bus.mem_hi      <= bus.mem_hi;
                    bus.mem_lo      <= bus.mem_lo;
                    bus.mem_whilo   <= bus.mem_whilo;
                    bus.hilo_temp_o <= bus.hilo_temp_o;
                    bus.cnt_o       <= bus.cnt_o;
                end
                default: begin
                    bus.mem_wreg    <= WRITE_DISA;
                    bus.mem_waddr   <= ZERO_ADDR;
                    bus.mem_wdata   <= ZERO_REG;
                    bus.mem_hi      <= ZERO_REG;
                    bus.mem_lo      <= ZERO_REG;
                    bus.mem_whilo   <= WRITE_DISA;
                    bus.hilo_temp_o <= ZERO_DBL;
                    bus.cnt_o       <= ZERO_CNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed vectors with literal expectations plus
// a behavioural model compared against the DUT on every falling clock edge.
module tb_ex_mem;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] temp;
        logic [1:0]  cnt;
    } out_t;

    logic       clk;
    logic       rst;
    logic [5:0] stall;
    logic       flush;

    int checks = 0;
    int errors = 0;

    ex_mem_if bus ();

    ex_mem dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t dut_out;
    out_t model;
    out_t snap;

    assign dut_out = '{wreg: bus.mem_wreg, waddr: bus.mem_waddr, wdata: bus.mem_wdata,
                       hi: bus.mem_hi, lo: bus.mem_lo, whilo: bus.mem_whilo,
                       temp: bus.hilo_temp_o, cnt: bus.cnt_o};

    // Reference: what the MEM stage and EX feedback must hold after each edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model <= '0;
        end else begin
            if (!stall[3] && stall[4]) begin
                checks++;
                errors++;
                $display("FAIL illegal_stall: stall=%b has EX running with MEM stopped", stall);
            end
            if (flush) begin
                model <= '0;
            end else if (stall[3] && !stall[4]) begin
                model <= '{wreg: 1'b0, waddr: 5'd0, wdata: 32'd0, hi: 32'd0, lo: 32'd0,
                           whilo: 1'b0, temp: bus.hilo_temp_i, cnt: bus.cnt_i};
            end else if (!stall[3]) begin
                model <= '{wreg: bus.ex_wreg, waddr: bus.ex_waddr, wdata: bus.ex_wdata,
                           hi: bus.ex_hi, lo: bus.ex_lo, whilo: bus.ex_whilo,
                           temp: 64'd0, cnt: 2'd0};
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (dut_out !== model) begin
                errors++;
                $display("FAIL model_cmp @%0t: got wreg=%b waddr=%0d wdata=%h hi=%h lo=%h whilo=%b temp=%h cnt=%0d, want wreg=%b waddr=%0d wdata=%h hi=%h lo=%h whilo=%b temp=%h cnt=%0d",
                         $time, dut_out.wreg, dut_out.waddr, dut_out.wdata, dut_out.hi, dut_out.lo,
                         dut_out.whilo, dut_out.temp, dut_out.cnt, model.wreg, model.waddr,
                         model.wdata, model.hi, model.lo, model.whilo, model.temp, model.cnt);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic wreg, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [63:0] temp, input logic [1:0] cnt);
        bus.ex_wreg     = wreg;
        bus.ex_waddr    = waddr;
        bus.ex_wdata    = wdata;
        bus.ex_whilo    = whilo;
        bus.ex_hi       = hi;
        bus.ex_lo       = lo;
        bus.hilo_temp_i = temp;
        bus.cnt_i       = cnt;
    endtask

    initial begin
        rst   = 1'b0;
        stall = 6'b000000;
        flush = 1'b0;
        set_ex(1'b1, 5'd7, 32'h1111_2222, 1'b1, 32'h3, 32'h4, 64'h55, 2'd3);
        step();
        step();
        check("reset_state", 64'(dut_out), 64'd0);
        check("reset_temp", dut_out.temp, 64'd0);
        rst = 1'b1;

        // Pass-through
        set_ex(1'b1, 5'd9, 32'h0000_1234, 1'b1, 32'h1, 32'h2, 64'h0, 2'd0);
        step();
        check("pass_wreg", 64'(bus.mem_wreg), 64'd1);
        check("pass_waddr", 64'(bus.mem_waddr), 64'd9);
        check("pass_wdata", 64'(bus.mem_wdata), 64'h1234);
        check("pass_whilo", 64'(bus.mem_whilo), 64'd1);
        check("pass_hi", 64'(bus.mem_hi), 64'd1);
        check("pass_lo", 64'(bus.mem_lo), 64'd2);
        check("pass_temp", bus.hilo_temp_o, 64'd0);
        check("pass_cnt", 64'(bus.cnt_o), 64'd0);

        // Bubble insert (cycle N of madd)
        stall = 6'b001111;
        set_ex(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 64'h0000_0001_8000_0000, 2'd1);
        step();
        check("bub_wreg", 64'(bus.mem_wreg), 64'd0);
        check("bub_wdata", 64'(bus.mem_wdata), 64'd0);
        check("bub_whilo", 64'(bus.mem_whilo), 64'd0);
        check("bub_temp", bus.hilo_temp_o, 64'h0000_0001_8000_0000);
        check("bub_cnt", 64'(bus.cnt_o), 64'd1);

        // Cycle N+1 of madd
        stall = 6'b000000;
        set_ex(1'b0, 5'd0, 32'h0, 1'b1, 32'h3, 32'h4, 64'h0, 2'd0);
        step();
        check("madd_hi", 64'(bus.mem_hi), 64'd3);
        check("madd_lo", 64'(bus.mem_lo), 64'd4);
        check("madd_whilo", 64'(bus.mem_whilo), 64'd1);
        check("madd_temp", bus.hilo_temp_o, 64'd0);
        check("madd_cnt", 64'(bus.cnt_o), 64'd0);

        // Hold after pass-through
        set_ex(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 32'h6, 32'h7, 64'h0, 2'd0);
        step();
        snap = dut_out;
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b0, 5'(i + 20), 32'(i * 32'h0101_0101), 1'b1, 32'(i), 32'(i + 8),
                   64'(i + 100), 2'(i + 1));
            step();
            check("hold_wdata", 64'(bus.mem_wdata), 64'hA5A5_A5A5);
            check("hold_all", 64'(dut_out ^ snap), 64'd0);
        end

        // Scratch survives a hold following a bubble
        stall = 6'b001111;
        set_ex(1'b1, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0, 64'hCAFE_0000_BEEF_0001, 2'd1);
        step();
        stall = 6'b011111;
        set_ex(1'b1, 5'd2, 32'h2, 1'b1, 32'h9, 32'h9, 64'h1234, 2'd2);
        step();
        step();
        check("hold_temp", bus.hilo_temp_o, 64'hCAFE_0000_BEEF_0001);
        check("hold_cnt", 64'(bus.cnt_o), 64'd1);

        // Flush beats bubble
        stall = 6'b001111;
        flush = 1'b1;
        set_ex(1'b1, 5'd2, 32'h2, 1'b1, 32'h9, 32'h9, 64'h1234, 2'd1);
        step();
        check("flush_all", 64'(dut_out), 64'd0);
        check("flush_temp", bus.hilo_temp_o, 64'd0);
        check("flush_cnt", 64'(bus.cnt_o), 64'd0);
        flush = 1'b0;

        // Mixed legal traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       stall = 6'b001111;
                1:       stall = 6'b011111;
                default: stall = 6'b000000;
            endcase
            flush = ($urandom_range(0, 9) == 0);
            set_ex(1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                   {$urandom, $urandom}, 2'($urandom));
            step();
        end
        flush = 1'b0;

        // Reset mid-stream, asynchronously between edges
        stall = 6'b000000;
        set_ex(1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd1);
        step();
        check("pre_rst_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_all", 64'(dut_out), 64'd0);
        check("async_rst_temp", bus.hilo_temp_o, 64'd0);
        step();
        rst = 1'b1;
        step();
        check("post_rst_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
